// File: rtl/pzcorebus_error_slave.sv
// Terminating pzcorebus slave: accepts every command, drains write data and answers with error responses.
// Define PZCOREBUS_ERROR_SLAVE_COUNTER_EN to add the saturating o_command_count accepted-command counter.
module pzcorebus_error_slave #(
  parameter int                    ID_WIDTH            = 8,
  parameter int                    ADDRESS_WIDTH       = 32,
  parameter int                    MAX_LENGTH          = 32,
  parameter int                    LENGTH_WIDTH        = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1,
  parameter int                    DATA_WIDTH          = 64,
  parameter int                    UNIT_DATA_WIDTH     = 32,
  parameter int                    REQUEST_INFO_WIDTH  = 4,
  parameter int                    RESPONSE_INFO_WIDTH = 4,
  parameter bit                    SERROR              = 1'b1,
  parameter logic [DATA_WIDTH-1:0] DUMMY_DATA          = '0
)(
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           mcmd_valid,
  output logic                           scmd_accept,
  input  logic [3:0]                     mcmd,
  input  logic [ID_WIDTH-1:0]            mid,
  input  logic [ADDRESS_WIDTH-1:0]       maddr,
  input  logic [LENGTH_WIDTH-1:0]        mlength,
  input  logic [REQUEST_INFO_WIDTH-1:0]  minfo,
  input  logic                           mdata_valid,
  output logic                           sdata_accept,
  input  logic [DATA_WIDTH-1:0]          mdata,
  input  logic [DATA_WIDTH/8-1:0]        mdata_byteen,
  input  logic                           mdata_last,
  output logic                           sresp_valid,
  input  logic                           mresp_accept,
  output logic [1:0]                     sresp,
  output logic [ID_WIDTH-1:0]            sid,
  output logic                           serror,
  output logic [DATA_WIDTH-1:0]          sdata,
  output logic [RESPONSE_INFO_WIDTH-1:0] sinfo,
  output logic                           sresp_uniq,
`ifdef PZCOREBUS_ERROR_SLAVE_COUNTER_EN
  output logic [15:0]                    o_command_count,
`endif
  output logic                           sresp_last
);
  // Command encoding: bit 3 = non-posted, bit 2 = carries write data.
  localparam int         NON_POSTED_BIT = 3;
  localparam int         WITH_DATA_BIT  = 2;
  localparam logic [3:0] CMD_READ       = 4'b1001;

  localparam logic [1:0] RESP_NULL      = 2'b00;
  localparam logic [1:0] RESP_NO_DATA   = 2'b01;
  localparam logic [1:0] RESP_WITH_DATA = 2'b11;

  localparam int WORDS       = DATA_WIDTH / UNIT_DATA_WIDTH;
  localparam int WORDS_SHIFT = (WORDS > 1) ? $clog2(WORDS) : 0;
  localparam int COUNT_WIDTH = LENGTH_WIDTH + 1;
  localparam int UNITS_WIDTH = COUNT_WIDTH + 1;

  localparam logic [COUNT_WIDTH-1:0] ONE_BEAT  = 1;
  localparam logic [COUNT_WIDTH-1:0] TWO_BEATS = 2;

  typedef logic [UNITS_WIDTH-1:0] units_t;
  typedef enum logic [1:0] {IDLE, DRAIN, RESPOND} state_e;

  state_e                 state;
  logic                   non_posted_q;
  logic [COUNT_WIDTH-1:0] beat_count;
  units_t                 length_units;
  logic [COUNT_WIDTH-1:0] read_beats;
  logic                   cmd_ack;
  logic                   data_ack;

  assign cmd_ack    = mcmd_valid && scmd_accept;
  assign data_ack   = mdata_valid && sdata_accept;
  assign sinfo      = '0;
  assign sresp_uniq = 1'b0;

  // Address, info and write payload are never inspected; an error slave only counts beats.
  logic unused_inputs;
  assign unused_inputs = ^{maddr, minfo, mdata, mdata_byteen};

  // mlength==0 encodes MAX_LENGTH; beats = ceil(units / words-per-beat).
  // NOTE: every always_comb output is assigned unconditionally so no latch can be inferred.
  always_comb begin
    length_units = (mlength == '0) ? units_t'(MAX_LENGTH) : units_t'(mlength);
    read_beats   = COUNT_WIDTH'((length_units + units_t'(WORDS - 1)) >> WORDS_SHIFT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      scmd_accept  <= 1'b1;
      sdata_accept <= 1'b0;
      sresp_valid  <= 1'b0;
      sresp        <= RESP_NULL;
      sid          <= '0;
      serror       <= 1'b0;
      sdata        <= '0;
      sresp_last   <= 1'b0;
      beat_count   <= '0;
      non_posted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          scmd_accept <= 1'b1;
          if (cmd_ack) begin
            // Response fields are loaded at acceptance so RESPOND only has to raise sresp_valid.
            scmd_accept  <= 1'b0;
            non_posted_q <= mcmd[NON_POSTED_BIT];
            sid          <= mid;
            serror       <= SERROR;
            if (mcmd == CMD_READ) begin
              sresp      <= RESP_WITH_DATA;
              sdata      <= DUMMY_DATA;
              beat_count <= read_beats;
              sresp_last <= (read_beats == ONE_BEAT);
            end else begin
              sresp      <= RESP_NO_DATA;
              beat_count <= ONE_BEAT;
              sresp_last <= 1'b1;
            end
            if (mcmd[WITH_DATA_BIT]) begin
              state        <= DRAIN;
              sdata_accept <= 1'b1;
            end else if (mcmd[NON_POSTED_BIT]) begin
              state       <= RESPOND;
              sresp_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (data_ack && mdata_last) begin
            sdata_accept <= 1'b0;
            if (non_posted_q) begin
              state       <= RESPOND;
              sresp_valid <= 1'b1;
            end else begin
              state       <= IDLE;
              scmd_accept <= 1'b1;
            end
          end
        end
        RESPOND: begin
          if (mresp_accept) begin
            if (beat_count == ONE_BEAT) begin
              state       <= IDLE;
              sresp_valid <= 1'b0;
              sresp       <= RESP_NULL;
              sresp_last  <= 1'b0;
              scmd_accept <= 1'b1;
            end else begin
              beat_count <= beat_count - ONE_BEAT;
              sresp_last <= (beat_count == TWO_BEATS);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PZCOREBUS_ERROR_SLAVE_COUNTER_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_command_count <= '0;
    end else if (cmd_ack && (o_command_count != 16'hFFFF)) begin
      o_command_count <= o_command_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pzcorebus_error_slave.sv
// Scoreboard bench for pzcorebus_error_slave: expected response beats are queued at command
// acceptance and compared beat by beat (including while stalled) as the DUT presents them.
module tb_pzcorebus_error_slave;
  localparam int MAX_LENGTH   = 32;
  localparam int LENGTH_WIDTH = 5;
  localparam int DATA_WIDTH   = 64;
  localparam int WORDS        = 2;

  localparam logic [3:0] CMD_MESSAGE    = 4'b0001;
  localparam logic [3:0] CMD_WRITE      = 4'b0101;
  localparam logic [3:0] CMD_READ       = 4'b1001;
  localparam logic [3:0] CMD_MESSAGE_NP = 4'b1010;
  localparam logic [3:0] CMD_WRITE_NP   = 4'b1101;
  localparam logic [3:0] CMD_ATOMIC     = 4'b1110;

  localparam logic [1:0] RESP_NO_DATA   = 2'b01;
  localparam logic [1:0] RESP_WITH_DATA = 2'b11;

  typedef struct packed {
    logic [1:0] sresp;
    logic [7:0] sid;
    logic       last;
    logic       is_read;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    i_rst_n;
  logic                    mcmd_valid;
  logic                    scmd_accept;
  logic [3:0]              mcmd;
  logic [7:0]              mid;
  logic [31:0]             maddr;
  logic [LENGTH_WIDTH-1:0] mlength;
  logic [3:0]              minfo;
  logic                    mdata_valid;
  logic                    sdata_accept;
  logic [DATA_WIDTH-1:0]   mdata;
  logic [7:0]              mdata_byteen;
  logic                    mdata_last;
  logic                    sresp_valid;
  logic                    mresp_accept;
  logic [1:0]              sresp;
  logic [7:0]              sid;
  logic                    serror;
  logic [DATA_WIDTH-1:0]   sdata;
  logic [3:0]              sinfo;
  logic                    sresp_uniq;
  logic                    sresp_last;
`ifdef PZCOREBUS_ERROR_SLAVE_COUNTER_EN
  logic [15:0]             o_command_count;
`endif

  exp_t exp_q[$];
  exp_t head;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   data_taken = 0;
  int   beats_seen = 0;
  int   exp_count  = 0;

  always #5 clk = ~clk;

  pzcorebus_error_slave dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .mcmd_valid      (mcmd_valid),
    .scmd_accept     (scmd_accept),
    .mcmd            (mcmd),
    .mid             (mid),
    .maddr           (maddr),
    .mlength         (mlength),
    .minfo           (minfo),
    .mdata_valid     (mdata_valid),
    .sdata_accept    (sdata_accept),
    .mdata           (mdata),
    .mdata_byteen    (mdata_byteen),
    .mdata_last      (mdata_last),
    .sresp_valid     (sresp_valid),
    .mresp_accept    (mresp_accept),
    .sresp           (sresp),
    .sid             (sid),
    .serror          (serror),
    .sdata           (sdata),
    .sinfo           (sinfo),
    .sresp_uniq      (sresp_uniq),
`ifdef PZCOREBUS_ERROR_SLAVE_COUNTER_EN
    .o_command_count (o_command_count),
`endif
    .sresp_last      (sresp_last)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int exp_beats(input int len);
    int units;
    units = (len == 0) ? MAX_LENGTH : len;
    return (units + WORDS - 1) / WORDS;
  endfunction

  // Monitor: handshakes complete on the next posedge, so sample at the negedge before it.
  always @(negedge clk) begin
    if (i_rst_n) begin
      if (mdata_valid && sdata_accept) data_taken++;
      if (sresp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          head = exp_q[0];
          check("sresp", sresp, head.sresp);
          check("sid", sid, head.sid);
          check("serror", serror, 1);
          check("sresp_last", sresp_last, head.last);
          check("sinfo_uniq", {sinfo, sresp_uniq}, 0);
          if (head.is_read) check("sdata", sdata, 0);
          if (mresp_accept) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
    end
  end

  // All driver tasks start and end 1 time unit after a posedge.
  task automatic send_cmd(input logic [3:0] cmd, input logic [7:0] id, input logic [LENGTH_WIDTH-1:0] len);
    bit accepted = 0;
    int n;
    mcmd_valid = 1'b1;
    mcmd       = cmd;
    mid        = id;
    mlength    = len;
    maddr      = $urandom;
    minfo      = 4'($urandom_range(0, 15));
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (scmd_accept) begin
        accepted = 1;
        exp_count++;
        if (cmd == CMD_READ) begin
          n = exp_beats(int'(len));
          for (int b = 0; b < n; b++) exp_q.push_back('{RESP_WITH_DATA, id, (b == n - 1), 1'b1});
        end else if (cmd[3]) begin
          exp_q.push_back('{RESP_NO_DATA, id, 1'b1, 1'b0});
        end
      end
      @(posedge clk); #1;
    end
    mcmd_valid = 1'b0;
    if (!accepted) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic send_data(input int beats);
    bit taken;
    for (int b = 0; b < beats; b++) begin
      mdata_valid = 1'b1;
      mdata       = {$urandom, $urandom};
      mdata_last  = (b == beats - 1);
      taken       = 0;
      for (int i = 0; i < 50 && !taken; i++) begin
        @(negedge clk);
        if (sdata_accept) taken = 1;
        @(posedge clk); #1;
      end
      if (!taken) check("data_accept_timeout", 0, 1);
    end
    mdata_valid = 1'b0;
    mdata_last  = 1'b0;
  endtask

  task automatic wait_resp_done();
    int i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(posedge clk); #1;
      i++;
    end
    check("resp_drained", exp_q.size(), 0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int taken0;
    int beats0;
    i_rst_n      = 1'b0;
    mcmd_valid   = 1'b0;
    mcmd         = '0;
    mid          = '0;
    maddr        = '0;
    mlength      = '0;
    minfo        = '0;
    mdata_valid  = 1'b0;
    mdata        = '0;
    mdata_byteen = '1;
    mdata_last   = 1'b0;
    mresp_accept = 1'b1;
    idle(3);

    check("rst_scmd_accept", scmd_accept, 1);
    check("rst_sdata_accept", sdata_accept, 0);
    check("rst_sresp_valid", sresp_valid, 0);
    check("rst_sresp_fields", {sresp, sid, serror, sresp_last, sinfo, sresp_uniq}, 0);
    check("rst_sdata", sdata, 0);
`ifdef PZCOREBUS_ERROR_SLAVE_COUNTER_EN
    check("rst_cmd_count", o_command_count, 0);
`endif
    i_rst_n = 1'b1;
    idle(2);

    // Read mid=5, mlength=8: four beats with one-cycle latency.
    send_cmd(CMD_READ, 8'd5, 5'd8);
    check("read_latency", sresp_valid, 1);
    check("read_busy_no_cmd_accept", scmd_accept, 0);
    wait_resp_done();

    // Posted write with three data beats: all drained, no response.
    taken0 = data_taken;
    send_cmd(CMD_WRITE, 8'd1, 5'd6);
    send_data(3);
    idle(3);
    check("posted_wr_beats", data_taken - taken0, 3);
    check("posted_wr_back_idle", scmd_accept, 1);

    // Non-posted write mid=2 with one beat.
    send_cmd(CMD_WRITE_NP, 8'd2, 5'd2);
    send_data(1);
    check("wr_np_resp_latency", sresp_valid, 1);
    wait_resp_done();

    // Read with mresp_accept held low for three cycles after the first beat.
    beats0 = beats_seen;
    send_cmd(CMD_READ, 8'd11, 5'd8);
    idle(1);
    mresp_accept = 1'b0;
    idle(3);
    mresp_accept = 1'b1;
    wait_resp_done();
    check("stall_beats", beats_seen - beats0, 4);

    // Data presented before its command must be held off.
    mdata_valid = 1'b1;
    mdata_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("early_data_held", sdata_accept, 0);
    end
    @(posedge clk); #1;
    taken0 = data_taken;
    send_cmd(CMD_WRITE_NP, 8'd7, 5'd1);
    send_data(1);
    wait_resp_done();
    check("early_data_beats", data_taken - taken0, 1);

    // Posted message: accept drops for one cycle, then returns.
    send_cmd(CMD_MESSAGE, 8'd3, 5'd0);
    check("msg_accept_low", scmd_accept, 0);
    idle(1);
    check("msg_accept_back", scmd_accept, 1);
    idle(2);

    // Non-posted message and atomic each give one no-data response.
    send_cmd(CMD_MESSAGE_NP, 8'd4, 5'd0);
    wait_resp_done();
    taken0 = data_taken;
    send_cmd(CMD_ATOMIC, 8'd9, 5'd4);
    send_data(2);
    wait_resp_done();
    check("atomic_beats", data_taken - taken0, 2);

    // Length boundaries: 0 means MAX_LENGTH, odd lengths round up.
    send_cmd(CMD_READ, 8'd20, 5'd0);
    wait_resp_done();
    send_cmd(CMD_READ, 8'd21, 5'd3);
    wait_resp_done();
    send_cmd(CMD_READ, 8'd22, 5'd1);
    wait_resp_done();
    for (int k = 0; k < 4; k++) begin
      send_cmd(CMD_READ, 8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)));
      wait_resp_done();
    end
`ifdef PZCOREBUS_ERROR_SLAVE_COUNTER_EN
    check("cmd_count", o_command_count, 16'(exp_count));
`endif

    // Reset asserted while beat 2 of a 4-beat read is on the bus.
    send_cmd(CMD_READ, 8'd5, 5'd8);
    idle(1);
    check("rst_mid_beat2_valid", sresp_valid, 1);
    i_rst_n = 1'b0;
    exp_q.delete();
    exp_count = 0;
    #1;
    check("rst_mid_resp_valid", sresp_valid, 0);
    check("rst_mid_scmd_accept", scmd_accept, 1);
    check("rst_mid_last", sresp_last, 0);
`ifdef PZCOREBUS_ERROR_SLAVE_COUNTER_EN
    check("rst_mid_cmd_count", o_command_count, 0);
`endif
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    idle(1);
    send_cmd(CMD_READ, 8'd6, 5'd2);
    check("post_rst_latency", sresp_valid, 1);
    wait_resp_done();
`ifdef PZCOREBUS_ERROR_SLAVE_COUNTER_EN
    check("post_rst_cmd_count", o_command_count, 16'(exp_count));
`endif
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
